// File: rtl/rf_exec_unit.sv
// Execute/writeback stage for a 2R/1W register file.
// Single-cycle ALU ops with WB forwarding; MUL is an iterative shift-add.
module rf_exec_unit #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            in_op,
    input  logic [ADDR_WIDTH-1:0] in_rd,
    input  logic [ADDR_WIDTH-1:0] in_rs1,
    input  logic [ADDR_WIDTH-1:0] in_rs2,
    input  logic [DATA_WIDTH-1:0] in_imm,
    output logic [ADDR_WIDTH-1:0] rf_read_addr1,
    output logic [ADDR_WIDTH-1:0] rf_read_addr2,
    input  logic [DATA_WIDTH-1:0] rf_read_data1,
    input  logic [DATA_WIDTH-1:0] rf_read_data2,
    output logic                  rf_we,
    output logic [ADDR_WIDTH-1:0] rf_write_addr,
    output logic [DATA_WIDTH-1:0] rf_write_data,
    output logic                  flag_zero,
    output logic                  flag_carry,
    output logic                  busy
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDI = 3'd5;
    localparam logic [2:0] OP_MUL = 3'd6;
    localparam logic [2:0] OP_NOP = 3'd7;

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t                r_state;
    logic                  r_wb_valid;
    logic [ADDR_WIDTH-1:0] r_wb_rd;
    logic [W-1:0]          r_wb_data;
    logic                  r_zero;
    logic                  r_carry;
    logic [2*W-1:0]        r_mcand;
    logic [W-1:0]          r_mplier;
    logic [2*W-1:0]        r_acc;
    logic [CW-1:0]         r_cnt;
    logic [ADDR_WIDTH-1:0] r_mul_rd;

    logic [W-1:0]   w_a;
    logic [W-1:0]   w_b;
    logic [W:0]     w_sum;
    logic [W:0]     w_diff;
    logic [W-1:0]   w_res;
    logic           w_cout;
    logic [2*W-1:0] w_step;
    logic           w_mul_done;
    logic           w_accept;

    assign in_ready      = (r_state == S_IDLE);
    assign busy          = (r_state == S_MUL);
    assign rf_read_addr1 = in_rs1;
    assign rf_read_addr2 = in_rs2;
    assign rf_we         = r_wb_valid;
    assign rf_write_addr = r_wb_rd;
    assign rf_write_data = r_wb_data;
    assign flag_zero     = r_zero;
    assign flag_carry    = r_carry;

    // The WB result is not yet in the file, so bypass it to either operand.
    assign w_a = (r_wb_valid && r_wb_rd == in_rs1) ? r_wb_data : rf_read_data1;
    assign w_b = (r_wb_valid && r_wb_rd == in_rs2) ? r_wb_data : rf_read_data2;

    assign w_sum      = {1'b0, w_a} + {1'b0, w_b};
    assign w_diff     = {1'b0, w_a} - {1'b0, w_b};
    assign w_step     = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_mul_done = (r_cnt == CW'(W - 1));
    assign w_accept   = in_valid && in_ready;

    always_comb begin
        w_res  = '0;
        w_cout = 1'b0;
        case (in_op)
            OP_ADD: begin
                w_res  = w_sum[W-1:0];
                w_cout = w_sum[W];
            end
            OP_SUB: begin
                w_res  = w_diff[W-1:0];
                w_cout = w_diff[W];
            end
            OP_AND:  w_res = w_a & w_b;
            OP_OR:   w_res = w_a | w_b;
            OP_XOR:  w_res = w_a ^ w_b;
            OP_LDI:  w_res = in_imm;
            default: w_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_wb_valid <= 1'b0;
            r_wb_rd    <= '0;
            r_wb_data  <= '0;
            r_zero     <= 1'b0;
            r_carry    <= 1'b0;
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_mul_rd   <= '0;
        end else begin
            r_wb_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept && in_op == OP_MUL) begin
                        r_mcand  <= {{W{1'b0}}, w_a};
                        r_mplier <= w_b;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_mul_rd <= in_rd;
                        r_state  <= S_MUL;
                    end else if (w_accept && in_op != OP_NOP) begin
                        r_wb_valid <= 1'b1;
                        r_wb_rd    <= in_rd;
                        r_wb_data  <= w_res;
                        r_zero     <= (w_res == '0);
                        r_carry    <= w_cout;
                    end
                end
                S_MUL: begin
                    r_acc    <= w_step;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_mul_done) begin
                        r_wb_valid <= 1'b1;
                        r_wb_rd    <= r_mul_rd;
                        r_wb_data  <= w_step[W-1:0];
                        r_zero     <= (w_step[W-1:0] == '0);
                        r_carry    <= |w_step[2*W-1:W];
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rf_exec_unit.sv
// Bench for rf_exec_unit: directed plan plus random ops checked against
// an architectural register model and an expected-writeback queue.
module tb_rf_exec_unit;
    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_op;
    logic [3:0] in_rd;
    logic [3:0] in_rs1;
    logic [3:0] in_rs2;
    logic [7:0] in_imm;
    logic [3:0] rf_read_addr1;
    logic [3:0] rf_read_addr2;
    logic [7:0] rf_read_data1;
    logic [7:0] rf_read_data2;
    logic       rf_we;
    logic [3:0] rf_write_addr;
    logic [7:0] rf_write_data;
    logic       flag_zero;
    logic       flag_carry;
    logic       busy;

    rf_exec_unit #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_imm(in_imm),
        .rf_read_addr1(rf_read_addr1), .rf_read_addr2(rf_read_addr2),
        .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
        .rf_we(rf_we), .rf_write_addr(rf_write_addr),
        .rf_write_data(rf_write_data),
        .flag_zero(flag_zero), .flag_carry(flag_carry), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file the DUT drives
    logic [7:0] rf [16];
    assign rf_read_data1 = rf[rf_read_addr1];
    assign rf_read_data2 = rf[rf_read_addr2];
    always @(posedge clk) if (rf_we) rf[rf_write_addr] <= rf_write_data;

    typedef struct {
        logic [3:0] a;
        logic [7:0] d;
        logic       z;
        logic       c;
    } wb_t;

    wb_t        q[$];
    logic [7:0] mreg [16];
    logic       mz;
    logic       mc;
    int         n_cmp = 0;
    int         n_err = 0;
    bit         started = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] ref_op(input logic [2:0] op,
                                          input int a, input int b,
                                          input int imm);
        int r;
        logic c;
        r = 0;
        c = 1'b0;
        case (op)
            3'd0: begin r = a + b; c = (r > 255); end
            3'd1: begin r = a - b; c = (a < b); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = imm;
            3'd6: begin r = a * b; c = (r > 255); end
            default: r = 0;
        endcase
        return {c, r[7:0]};
    endfunction

    // Every write leaving the DUT must match the next expected result
    always @(negedge clk) begin
        if (started && rf_we) begin
            chk("wb_pending", 32'(q.size() > 0), 1);
            if (q.size() > 0) begin
                chk("wb_addr", rf_write_addr, q[0].a);
                chk("wb_data", rf_write_data, q[0].d);
                chk("wb_zero", flag_zero, q[0].z);
                chk("wb_carry", flag_carry, q[0].c);
                void'(q.pop_front());
            end
        end
    end

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic issue(input logic [2:0] op, input logic [3:0] rd,
                         input logic [3:0] rs1, input logic [3:0] rs2,
                         input logic [7:0] imm);
        int n;
        logic [8:0] r;
        wb_t e;
        in_valid = 1'b1;
        in_op = op;
        in_rd = rd;
        in_rs1 = rs1;
        in_rs2 = rs2;
        in_imm = imm;
        n = 0;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) chk("issue_timeout", 32'(n), 0);
        @(posedge clk);
        #1;
        r = ref_op(op, int'(mreg[rs1]), int'(mreg[rs2]), int'(imm));
        if (op != 3'd7) begin
            mreg[rd] = r[7:0];
            mz = (r[7:0] == 8'h00);
            mc = r[8];
            e.a = rd;
            e.d = r[7:0];
            e.z = mz;
            e.c = mc;
            q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int bc;
        int wcnt;
        int wat;
        logic [7:0] wdat;
        logic wc;
        mz = 1'b0;
        mc = 1'b0;
        rst = 1'b1;
        in_valid = 1'b0;
        in_op = 3'd7;
        in_rd = '0;
        in_rs1 = '0;
        in_rs2 = '0;
        in_imm = '0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_waddr", rf_write_addr, 0);
        chk("rst_wdata", rf_write_data, 0);
        chk("rst_zero", flag_zero, 0);
        chk("rst_carry", flag_carry, 0);
        rst = 1'b0;
        started = 1;
        @(negedge clk);
        chk("post_rst_ready", in_ready, 1);

        // LDI, LDI, dependent ADD back to back
        issue(3'd5, 4'd1, 4'd0, 4'd0, 8'h05);
        issue(3'd5, 4'd2, 4'd0, 4'd0, 8'h03);
        issue(3'd0, 4'd3, 4'd1, 4'd2, 8'h00);
        chk("add_we", rf_we, 1);
        chk("add_data", rf_write_data, 8'h08);
        chk("add_zero", flag_zero, 0);
        chk("add_carry", flag_carry, 0);

        // Overflow and borrow
        issue(3'd5, 4'd1, 4'd0, 4'd0, 8'hFF);
        issue(3'd5, 4'd2, 4'd0, 4'd0, 8'h01);
        issue(3'd0, 4'd4, 4'd1, 4'd2, 8'h00);
        chk("ovf_data", rf_write_data, 8'h00);
        chk("ovf_zero", flag_zero, 1);
        chk("ovf_carry", flag_carry, 1);
        issue(3'd1, 4'd5, 4'd2, 4'd1, 8'h00);
        chk("sub_data", rf_write_data, 8'h02);
        chk("sub_carry", flag_carry, 1);
        chk("sub_zero", flag_zero, 0);

        // MUL with held dependent ADD
        issue(3'd5, 4'd1, 4'd0, 4'd0, 8'h10);
        issue(3'd5, 4'd2, 4'd0, 4'd0, 8'h20);
        issue(3'd6, 4'd6, 4'd1, 4'd2, 8'h00);
        in_op = 3'd0;
        in_rd = 4'd7;
        in_rs1 = 4'd6;
        in_rs2 = 4'd6;
        bc = 0;
        while (busy && bc < 20) begin
            chk("mul_ready_low", in_ready, 0);
            @(negedge clk);
            bc++;
        end
        chk("mul_busy_cycles", 32'(bc), 8);
        chk("mul_ready_back", in_ready, 1);
        chk("mul_we", rf_we, 1);
        chk("mul_data", rf_write_data, 8'h00);
        chk("mul_carry", flag_carry, 1);
        issue(3'd0, 4'd7, 4'd6, 4'd6, 8'h00);
        chk("mul_fwd_addr", rf_write_addr, 4'd7);
        chk("mul_fwd_data", rf_write_data, 8'h00);

        // MUL writeback timing
        issue(3'd5, 4'd1, 4'd0, 4'd0, 8'h0C);
        issue(3'd5, 4'd2, 4'd0, 4'd0, 8'h0A);
        issue(3'd6, 4'd8, 4'd1, 4'd2, 8'h00);
        in_valid = 1'b0;
        wcnt = 0;
        wat = -1;
        wdat = '0;
        wc = 1'b1;
        for (int m = 0; m <= 12; m++) begin
            if (rf_we) begin
                wcnt++;
                wat = m;
                wdat = rf_write_data;
                wc = flag_carry;
            end
            @(negedge clk);
        end
        chk("mul2_we_count", 32'(wcnt), 1);
        chk("mul2_we_cycle", 32'(wat), 8);
        chk("mul2_data", wdat, 8'h78);
        chk("mul2_carry", wc, 0);

        // Reset in the middle of a MUL
        issue(3'd6, 4'd9, 4'd1, 4'd2, 8'h00);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        q.delete();
        mz = 1'b0;
        mc = 1'b0;
        @(negedge clk);
        chk("abort_we", rf_we, 0);
        chk("abort_busy", busy, 0);
        chk("abort_ready", in_ready, 1);
        chk("abort_zero", flag_zero, 0);
        chk("abort_carry", flag_carry, 0);
        chk("abort_wdata", rf_write_data, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_ready2", in_ready, 1);
        idle(10);

        // NOP holds flags; chained self-add
        issue(3'd5, 4'd1, 4'd0, 4'd0, 8'h00);
        issue(3'd0, 4'd11, 4'd1, 4'd1, 8'h00);
        chk("zadd_zero", flag_zero, 1);
        issue(3'd7, 4'd11, 4'd1, 4'd1, 8'h00);
        chk("nop_we", rf_we, 0);
        chk("nop_zero", flag_zero, 1);
        chk("nop_carry", flag_carry, 0);
        issue(3'd5, 4'd1, 4'd0, 4'd0, 8'h40);
        issue(3'd0, 4'd1, 4'd1, 4'd1, 8'h00);
        chk("dbl1_data", rf_write_data, 8'h80);
        chk("dbl1_carry", flag_carry, 0);
        issue(3'd0, 4'd1, 4'd1, 4'd1, 8'h00);
        chk("dbl2_data", rf_write_data, 8'h00);
        chk("dbl2_carry", flag_carry, 1);
        chk("dbl2_zero", flag_zero, 1);

        // Random phase
        for (int r = 0; r < 16; r++)
            issue(3'd5, 4'(r), 4'd0, 4'd0, 8'($urandom_range(0, 255)));
        for (int i = 0; i < 300; i++) begin
            issue(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  8'($urandom_range(0, 255)));
            if ($urandom_range(0, 3) == 0) idle(1);
            else if (busy === 1'b0 && $urandom_range(0, 7) == 0) begin
                issue(3'd7, 4'd0, 4'd0, 4'd0, 8'h00);
                chk("rnd_nop_zero", flag_zero, mz);
                chk("rnd_nop_carry", flag_carry, mc);
            end
        end
        idle(14);
        chk("queue_drained", 32'(q.size()), 0);
        for (int r = 0; r < 16; r++)
            chk($sformatf("rf_r%0d", r), rf[r], mreg[r]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
